// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port unified RAM between the fetch stage and
// the MEM stage. Each granted access holds the RAM port for MEM_LATENCY
// cycles, then returns a one-cycle registered ready pulse with read data.
// Optional feature macro: MEM_ARB_RR_EN (round-robin on contention; when
// undefined, data always beats fetch).
module mem_arbiter #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned MEM_LATENCY = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ready,
   input  logic              mem_re,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_ready,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              stall_fetch,
   output logic              stall_mem
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LATENCY);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      BUSY_IF  = 2'd1,
      BUSY_MEM = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ram_en_d, ram_we_d;
   logic [ADDR_W-1:0]  ram_addr_d;
   logic [DATA_W-1:0]  ram_wdata_d, if_rdata_d, mem_rdata_d;
   logic               if_ready_d, mem_ready_d;
   logic               mem_elig, if_elig, pick_mem;

`ifdef MEM_ARB_RR_EN
   // 1 = data was served last, 0 = fetch was served last
   logic               last_grant_q, last_grant_d;
`endif

   // A requester whose ready is up this cycle holds a stale request
   assign mem_elig = (mem_re | mem_we) & ~mem_ready;
   assign if_elig  = if_req & ~if_ready;

   // Stalls drop in the ready cycle so the pipeline advances at that edge
   assign stall_fetch = if_req & ~if_ready;
   assign stall_mem   = (mem_re | mem_we) & ~mem_ready;

   // Winner selection when a grant is possible
   always_comb begin
      pick_mem = mem_elig;
`ifdef MEM_ARB_RR_EN
      if (mem_elig && if_elig) pick_mem = ~last_grant_q;
`endif
   end

   // Next-state and next-output logic
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ram_en_d    = ram_en;
      ram_we_d    = ram_we;
      ram_addr_d  = ram_addr;
      ram_wdata_d = ram_wdata;
      if_rdata_d  = if_rdata;
      mem_rdata_d = mem_rdata;
      if_ready_d  = 1'b0;
      mem_ready_d = 1'b0;
`ifdef MEM_ARB_RR_EN
      last_grant_d = last_grant_q;
`endif
      case (state_q)
         IDLE: begin
            if (pick_mem) begin
               state_d     = BUSY_MEM;
               cnt_d       = CNT_W'(1);
               ram_en_d    = 1'b1;
               ram_we_d    = mem_we;
               ram_addr_d  = mem_addr;
               ram_wdata_d = mem_wdata;
`ifdef MEM_ARB_RR_EN
               last_grant_d = 1'b1;
`endif
            end else if (if_elig) begin
               state_d    = BUSY_IF;
               cnt_d      = CNT_W'(1);
               ram_en_d   = 1'b1;
               ram_we_d   = 1'b0;
               ram_addr_d = if_addr;
`ifdef MEM_ARB_RR_EN
               last_grant_d = 1'b0;
`endif
            end else begin
               ram_en_d = 1'b0;
               ram_we_d = 1'b0;
            end
         end
         BUSY_IF, BUSY_MEM: begin
            if (cnt_q == LAT) begin
               state_d  = IDLE;
               cnt_d    = '0;
               ram_en_d = 1'b0;
               ram_we_d = 1'b0;
               if (state_q == BUSY_IF) begin
                  if_rdata_d = ram_rdata;
                  if_ready_d = 1'b1;
               end else begin
                  mem_ready_d = 1'b1;
                  if (!ram_we) mem_rdata_d = ram_rdata;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d  = IDLE;
            cnt_d    = '0;
            ram_en_d = 1'b0;
            ram_we_d = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset abandons any in-flight access
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         ram_en    <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         if_rdata  <= '0;
         mem_rdata <= '0;
         if_ready  <= 1'b0;
         mem_ready <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ram_en    <= ram_en_d;
         ram_we    <= ram_we_d;
         ram_addr  <= ram_addr_d;
         ram_wdata <= ram_wdata_d;
         if_rdata  <= if_rdata_d;
         mem_rdata <= mem_rdata_d;
         if_ready  <= if_ready_d;
         mem_ready <= mem_ready_d;
      end
   end

`ifdef MEM_ARB_RR_EN
   // Round-robin history; starts at "fetch" so data wins the first tie
   always_ff @(posedge clock or posedge reset) begin
      if (reset) last_grant_q <= 1'b0;
      else       last_grant_q <= last_grant_d;
   end
`endif

endmodule
